// File: rtl/regfile_dump_scanner_pkg.sv
// Shared definitions for the register-file dump scanner: FSM encoding,
// default halt address and dump index width.
package regfile_dump_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_PC = 32'hF000_0000;
  localparam int          IDX_W           = 6;

endpackage

// File: rtl/regfile_dump_scanner_out.sv
// Output holding register for the dump stream: loads an {idx, data} word and
// keeps it stable until the consumer accepts it.
module dump_out_reg
  import regfile_dump_scanner_pkg::*;
#(
  parameter int W_IDX  = IDX_W,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [W_IDX-1:0]  load_idx,
  input  logic [W_DATA-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [W_IDX-1:0]  idx,
  output logic [W_DATA-1:0] data
);

  // load wins over a handshake so a new word can follow back-to-back
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      idx   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      idx   <= load_idx;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_scanner.sv
// Freezes the CPU at HALT_PC (or on start) and streams x0..x(NREGS-1) out of
// the debug port as indexed words. Define DUMP_PC_EN to append the trigger PC.
module regfile_dump_scanner
  import regfile_dump_scanner_pkg::*;
#(
  parameter logic [31:0] HALT_PC = DEFAULT_HALT_PC,
  parameter int          NREGS   = 32,
  parameter int          RD_LAT  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      pc,
  input  logic             start,
  input  logic [31:0]      reg_data,
  output logic [4:0]       reg_sel,
  output logic             cpu_hold,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [31:0]      dump_data,
  output logic             busy,
  output logic             dump_done,
  output state_t           state_dbg
);

  // Handshake: a word transfers on a rising clk edge with dump_valid && dump_ready;
  // once dump_valid is high, dump_idx/dump_data stay stable until that edge.

  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [WCNT_W-1:0]  wcnt;
  logic               armed;
  logic               pc_hit, trig, hs, last_reg;
  logic               take_trig, sample, advance, pc_word;
  logic [IDX_W-1:0]   load_idx;
  logic [31:0]        load_data;

  assign pc_hit    = (pc == HALT_PC);
  assign trig      = start | (armed & pc_hit);
  assign hs        = dump_valid & dump_ready;
  assign last_reg  = (idx == IDX_W'(NREGS - 1));
  assign dump_done = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_trig = 1'b0;
    sample    = 1'b0;
    advance   = 1'b0;
    pc_word   = 1'b0;
    case (state)
      S_IDLE: if (trig) begin
        take_trig = 1'b1;
        state_nxt = S_SEL;
      end
      S_SEL: if (wcnt == '0) begin
        sample    = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: if (hs) begin
`ifdef DUMP_PC_EN
        if (idx == IDX_W'(NREGS)) begin
          state_nxt = S_DONE;
        end else if (last_reg) begin
          pc_word = 1'b1;
        end else begin
          advance   = 1'b1;
          state_nxt = S_SEL;
        end
`else
        if (last_reg) begin
          state_nxt = S_DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = S_SEL;
        end
`endif
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // armed blocks re-triggering while the CPU sits at HALT_PC after a dump
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx      <= '0;
      reg_sel  <= '0;
      wcnt     <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      armed    <= 1'b1;
    end else begin
      if (!pc_hit)                 armed <= 1'b1;
      else if (take_trig && armed) armed <= 1'b0;

      if (take_trig) begin
        idx      <= '0;
        reg_sel  <= '0;
        wcnt     <= WCNT_W'(RD_LAT - 1);
        cpu_hold <= 1'b1;
        busy     <= 1'b1;
      end else if (state == S_SEL && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end

      if (advance) begin
        idx     <= idx + 1'b1;
        reg_sel <= 5'(idx + 1'b1);
        wcnt    <= WCNT_W'(RD_LAT - 1);
      end

      if (pc_word) idx <= IDX_W'(NREGS);

      if (state == S_DONE) begin
        cpu_hold <= 1'b0;
        busy     <= 1'b0;
        reg_sel  <= '0;
      end
    end
  end

`ifdef DUMP_PC_EN
  logic [31:0] pc_lat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          pc_lat <= '0;
    else if (take_trig) pc_lat <= pc;
  end

  assign load_idx  = pc_word ? IDX_W'(NREGS) : idx;
  assign load_data = pc_word ? pc_lat : reg_data;
`else
  assign load_idx  = idx;
  assign load_data = reg_data;
`endif

  dump_out_reg #(
    .W_IDX  (IDX_W),
    .W_DATA (32)
  ) u_out (
    .clk       (clk),
    .rstn      (rstn),
    .load      (sample | pc_word),
    .load_idx  (load_idx),
    .load_data (load_data),
    .ready     (dump_ready),
    .valid     (dump_valid),
    .idx       (dump_idx),
    .data      (dump_data)
  );

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// Bench for regfile_dump_scanner: expected-word queue built from a register
// file array, trigger vector table, plus timing/backpressure/reset sequences.
module tb_regfile_dump_scanner;
  import regfile_dump_scanner_pkg::*;

  localparam int NREGS  = 32;
  localparam int RD_LAT = 1;
`ifdef DUMP_PC_EN
  localparam int NWORDS = NREGS + 1;
`else
  localparam int NWORDS = NREGS;
`endif
  // every register costs RD_LAT+1 cycles, a PC word costs one, DONE costs one
  localparam int FULL_CYC = NREGS * (RD_LAT + 1) + (NWORDS - NREGS) + 1;

  logic             clk, rstn, start, dump_ready;
  logic [31:0]      pc, reg_data, dump_data;
  logic [4:0]       reg_sel;
  logic             cpu_hold, dump_valid, busy, dump_done;
  logic [IDX_W-1:0] dump_idx;
  state_t           state_dbg;

  logic [31:0]      rf [NREGS];
  logic [37:0]      exp_q [$];
  int               total, bad, done_cnt, first_valid, last_idx;
  logic [31:0]      last_trig_pc;
  bit               prev_stall;
  logic [37:0]      stall_word;

  assign reg_data = rf[reg_sel];

  regfile_dump_scanner #(
    .HALT_PC (DEFAULT_HALT_PC),
    .NREGS   (NREGS),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .start      (start),
    .reg_data   (reg_data),
    .reg_sel    (reg_sel),
    .cpu_hold   (cpu_hold),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .busy       (busy),
    .dump_done  (dump_done),
    .state_dbg  (state_dbg)
  );

  // clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] trig_pc);
    last_trig_pc = trig_pc;
    for (int i = 0; i < NREGS; i++) exp_q.push_back({6'(i), rf[i]});
`ifdef DUMP_PC_EN
    exp_q.push_back({6'(NREGS), last_trig_pc});
`endif
  endtask

  task automatic preload_rf();
    for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[0] = 32'h0;
  endtask

  task automatic random_rf();
    for (int i = 1; i < NREGS; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
  endtask

  // scoreboard: pops one expected word per accepted handshake
  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) check("stall_hold", {1'b1, dump_valid, dump_idx, dump_data}, {2'b11, stall_word});
      prev_stall = dump_valid && !dump_ready;
      stall_word = {dump_idx, dump_data};
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got idx %0d data %0h, none expected", dump_idx, dump_data);
        end else begin
          check("word", {dump_idx, dump_data}, exp_q.pop_front());
        end
        last_idx = int'(dump_idx);
      end
      if (dump_done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic wait_done(input int mode, input int budget, output int cycles);
    bit seen;
    int drops;
    seen = 0;
    drops = 0;
    cycles = 0;
    first_valid = -1;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      dump_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (dump_valid && first_valid < 0) first_valid = cycles;
      if (!cpu_hold) drops++;
      if (dump_done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("hold_during_dump", 64'(drops), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
    dump_ready = 1'b1;
    @(negedge clk);
    check("idle_after_done", {busy, cpu_hold, dump_valid, dump_done}, 64'd0);
  endtask

  typedef struct {
    logic [31:0] vpc;
    logic        vstart;
    logic        exp_trig;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc, dcnt;
    bit found;
    total = 0; bad = 0; done_cnt = 0; last_idx = -1; prev_stall = 0;
    stall_word = '0; last_trig_pc = '0;
    rstn = 1'b0; pc = 32'h0; start = 1'b0; dump_ready = 1'b1;
    preload_rf();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {reg_sel, cpu_hold, dump_valid, dump_idx, busy, dump_done}, 64'd0);
    check("reset_data", dump_data, 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    // PC-match dump, ready tied high: timing and contents
    pc = DEFAULT_HALT_PC;
    push_dump(pc);
    @(negedge clk);
    check("trig_cycle_idle", {busy, dump_valid}, 64'd0);
    wait_done(0, 400, cyc);
    check("done_cycle", 64'(cyc), 64'(FULL_CYC));
    check("first_valid", 64'(first_valid), 64'(RD_LAT + 1));
    check("last_idx_full", 64'(last_idx), 64'(NWORDS - 1));

    // holding HALT_PC must not re-trigger
    repeat (200 - cyc) tick();
    @(negedge clk);
    check("single_dump_at_halt", {31'(done_cnt), busy}, {31'd1, 1'b0});

    // leaving and returning to HALT_PC re-arms
    tick();
    pc = 32'h0;
    tick();
    pc = DEFAULT_HALT_PC;
    random_rf();
    push_dump(pc);
    wait_done(1, 2000, cyc);
    check("second_dump", 64'(done_cnt), 64'd2);

    // backpressure: ready low for 10 cycles on word 7
    preload_rf();
    pc = 32'h0000_0040;
    tick();
    start = 1'b1;
    push_dump(pc);
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy && !dump_valid && reg_sel == 5'd7) found = 1;
      else tick();
    end
    check("bp_reach_idx7", 64'(found), 64'd1);
    tick();
    dump_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_word", {dump_valid, dump_idx, dump_data}, {1'b1, 6'd7, 32'h1000_0007});
      if (i < 9) tick();
    end
    wait_done(1, 2000, cyc);
    check("bp_last_idx", 64'(last_idx), 64'(NWORDS - 1));

    // start while busy is ignored, not queued
    tick();
    start = 1'b1;
    push_dump(pc);
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 400, cyc);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("start_not_queued", 64'(busy), 64'd0);
    end
    tick();
    start = 1'b1;
    random_rf();
    push_dump(pc);
    tick();
    start = 1'b0;
    wait_done(1, 2000, cyc);

    // reset in the middle of a dump, then re-trigger from held HALT_PC
    tick();
    pc = DEFAULT_HALT_PC;
    preload_rf();
    push_dump(pc);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dump_valid && dump_idx == 6'd12) found = 1;
      else tick();
    end
    check("rst_reach_idx12", 64'(found), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_async_drop", {dump_valid, busy, cpu_hold, dump_done}, 64'd0);
    exp_q.delete();
    dcnt = done_cnt;
    repeat (3) tick();
    @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'(dcnt));
    tick();
    rstn = 1'b1;
    push_dump(pc);
    wait_done(0, 400, cyc);
    check("rst_redump_cycle", 64'(cyc), 64'(FULL_CYC));

    // trigger decision table, each from an armed idle state
    vecs[0] = '{32'h0000_0040,         1'b0, 1'b0};
    vecs[1] = '{32'h0000_0040,         1'b1, 1'b1};
    vecs[2] = '{DEFAULT_HALT_PC,       1'b0, 1'b1};
    vecs[3] = '{DEFAULT_HALT_PC,       1'b1, 1'b1};
    vecs[4] = '{32'hF000_0004,         1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000,         1'b1, 1'b1};
    for (int v = 0; v < 6; v++) begin
      tick();
      pc = 32'h0;
      tick();
      random_rf();
      pc = vecs[v].vpc;
      start = vecs[v].vstart;
      if (vecs[v].exp_trig) push_dump(pc);
      tick();
      start = 1'b0;
      @(negedge clk);
      check("vec_trig", 64'(busy), 64'(vecs[v].exp_trig));
      if (vecs[v].exp_trig) wait_done(1, 2000, cyc);
      for (int i = 0; i < 3; i++) begin
        tick();
        @(negedge clk);
        check("vec_no_retrig", 64'(busy), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
